aes256_key_schedule_ctrl: RTL and testbench
===========================================

// Module: aes256_key_schedule_ctrl
// PURPOSE
//  Sequences the combinational keyExpansion datapath to build all 15 AES-256 round keys from a
//  256-bit cipher key. Keys are stored in an internal 15x128 round-key buffer. Sits between the
//  key loader (valid/ready) and the round engines, which read keys by index once keys_valid=1.
// PARAMETERS
//  KEY_W   256  cipher key width; fixed, do not override
//  RK_W    128  round-key width; fixed
//  NUM_RK  15   number of round keys (Nr+1); fixed
//  AW      4    rk_addr width
// PORTS
//  clk         in   1    single clock, rising edge
//  rst         in   1    synchronous reset, active-high
//  key_in      in   256  cipher key, w0 in [255:224]
//  key_valid   in   1    key_in valid
//  key_ready   out  1    block can accept a key
//  busy        out  1    expansion in progress
//  keys_valid  out  1    all 15 round keys present and readable
//  rk_addr     in   4    round-key index 0..14
//  rk_out      out  128  round key for rk_addr (registered)
//  zeroize     in   1    present only with KEYSCHED_ZEROIZE_EN
// BEHAVIOUR
//  - Reset: FSM=IDLE. key_ready=1, busy=0, keys_valid=0, rc=0, rk_out=0.
//  - FSM states: IDLE, EXPAND, READY.
//  - IDLE/READY: key_ready=1. A handshake is key_valid&key_ready. On a handshake:
//    work<=key_in; rk[0]<=key_in[255:128]; rk[1]<=key_in[127:0]; rc<=0; keys_valid<=0;
//    state<=EXPAND.
//  - EXPAND: key_ready=0, busy=1. Each cycle, keyExpansion(rc, work) produces keyout.
//    work<=keyout. rk[2+2rc]<=keyout[255:128].
//    For rc<6: rk[3+2rc]<=keyout[127:0]. For rc=6: the upper half only (rk[14]); this is the last step.
//    rc increments each cycle. After the rc=6 step: state<=READY, keys_valid<=1.
//  - Latency: keys_valid rises exactly 8 cycles after the accepting edge (1 capture + 7 steps).
//  - rc is 3 bits, range 0..6. It is zero-extended to the 4-bit keyExpansion rc port.
//    rc never wraps; the value 7 is unreachable.
//  - Read port: rk_out <= (keys_valid && rk_addr<=14) ? rk[rk_addr] : 0, with 1-cycle latency.
//    rk_addr 15 returns 0.
//  - A new key accepted in READY restarts expansion and clears keys_valid on the next edge.
//  - key_valid while in EXPAND is ignored; the requester must hold it until key_ready.
//  - rst mid-EXPAND forces IDLE with keys_valid=0. Partial buffer contents are never exposed.
// CONFIGURATION
//  KEYSCHED_ZEROIZE_EN defined:
//  - Adds the zeroize input.
//  - zeroize=1 clears all rk[] entries and work in one cycle, forces IDLE, keys_valid=0, rk_out=0.
//  - key_ready=0 while zeroize=1, so zeroize beats a simultaneous key_valid.
//  - rst also clears rk[] and work.
//  KEYSCHED_ZEROIZE_EN undefined:
//  - No zeroize port.
//  - rst does not clear rk[]/work; contents stay hidden behind keys_valid.
// STRUCTURE
//  - Shared package aes_keysched_pkg: FSM state encoding (IDLE/EXPAND/READY), NUM_RK=15,
//    LAST_RC=6, RK_W=128.
//  - One sub-module: the existing keyExpansion, instanced once and reused each EXPAND cycle.
//  - The round-key buffer is a local register array, not a separate module.
// TESTING
//  1 Key 000102..1e1f -> keys_valid 8 cycles after handshake.
//    rk[1]=101112131415161718191a1b1c1d1e1f, rk[2]=a573c29fa176c498a97fce93a572c09c,
//    rk[14]=24fc79ccbf0979e9371ac23c6d68de36.
//  2 key_valid held high during EXPAND with a 2nd key -> ignored until READY.
//    The 2nd key is then accepted, keys_valid drops 1 cycle later and reasserts 8 cycles after.
//  3 rst pulsed at EXPAND cycle 3 -> IDLE, keys_valid=0, rk_out=0.
//    A re-issued key then yields the full FIPS-197 C.3 schedule.
//  4 Read sweep rk_addr 0..15 in READY -> rk_out matches the model 1 cycle later.
//    addr 15 returns 0. Any read while keys_valid=0 returns 0.
//  5 All-ff key (ffff..ff) -> all 15 keys match the reference model. rc sequence 0..6 observed once.
//  6 (ZEROIZE_EN) zeroize and key_valid in the same READY cycle -> key rejected, keys_valid=0.
//    Read of rk_addr 14 returns 0 after re-expansion is withheld.

Source files
------------

// File: rtl/aes_keysched_pkg.sv
// Shared constants and FSM encoding for the AES-256 key schedule controller.
package aes_keysched_pkg;
    localparam int         KEY_W   = 256;
    localparam int         RK_W    = 128;
    localparam int         NUM_RK  = 15;
    localparam int         AW      = 4;
    localparam logic [2:0] LAST_RC = 3'd6;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EXPAND = 2'd1,
        ST_READY  = 2'd2
    } ks_state_e;
endpackage

// File: rtl/aes256_key_schedule_ctrl_if.sv
// Key-load handshake and round-key read port of the AES-256 key schedule controller.
interface aes256_key_schedule_ctrl_if;
    import aes_keysched_pkg::*;

    logic [KEY_W-1:0] key_in;
    logic             key_valid;
    logic             key_ready;
    logic             busy;
    logic             keys_valid;
    logic [AW-1:0]    rk_addr;
    logic [RK_W-1:0]  rk_out;

    modport master (output key_in, key_valid, rk_addr,
                    input  key_ready, busy, keys_valid, rk_out);
    modport slave  (input  key_in, key_valid, rk_addr,
                    output key_ready, busy, keys_valid, rk_out);
endinterface

// File: rtl/aes256_key_schedule_ctrl_keyexp.sv
// One AES-256 expansion step: eight new words w[8..15] from w[0..7] and round index rc_i.
module keyExpansion
    import aes_keysched_pkg::*;
(
    input  logic [3:0]       rc_i,
    input  logic [KEY_W-1:0] key_i,
    output logic [KEY_W-1:0] key_o
);
    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = SBOX[w[8*i +: 8]];
        return r;
    endfunction

    logic [7:0]  rcon;
    logic [31:0] w [8];
    logic [31:0] n [8];

    assign rcon = 8'h01 << rc_i;

    always_comb begin
        for (int i = 0; i < 8; i++) w[i] = key_i[KEY_W-1-32*i -: 32];
        // rotated+substituted word feeds the first half, plain substitution the second
        n[0]  = w[0] ^ sub_word({w[7][23:0], w[7][31:24]}) ^ {rcon, 24'h0};
        n[1]  = w[1] ^ n[0];
        n[2]  = w[2] ^ n[1];
        n[3]  = w[3] ^ n[2];
        n[4]  = w[4] ^ sub_word(n[3]);
        n[5]  = w[5] ^ n[4];
        n[6]  = w[6] ^ n[5];
        n[7]  = w[7] ^ n[6];
        key_o = {n[0], n[1], n[2], n[3], n[4], n[5], n[6], n[7]};
    end
endmodule

// File: rtl/aes256_key_schedule_ctrl.sv
// Builds all 15 AES-256 round keys by stepping keyExpansion 7 times; keys readable by index.
// Optional KEYSCHED_ZEROIZE_EN adds a zeroize input that wipes the key buffer.
module aes256_key_schedule_ctrl
    import aes_keysched_pkg::*;
(
    input  logic clk,
    input  logic rst,
`ifdef KEYSCHED_ZEROIZE_EN
    input  logic zeroize,
`endif
    aes256_key_schedule_ctrl_if.slave kif
);
    ks_state_e        state_q, state_d;
    logic [2:0]       rc_q;
    logic [KEY_W-1:0] work_q, work_d, keyout;
    logic [RK_W-1:0]  rk_q [NUM_RK];
    logic [RK_W-1:0]  rk_d [NUM_RK];
    logic             keys_valid_q;
    logic [RK_W-1:0]  rk_out_q;
    logic             key_ready, busy, load, step, zero_req;
    logic [AW-1:0]    idx_hi, idx_lo;

`ifdef KEYSCHED_ZEROIZE_EN
    assign zero_req = zeroize;
`else
    assign zero_req = 1'b0;
`endif

    keyExpansion u_kexp (
        .rc_i  ({1'b0, rc_q}),
        .key_i (work_q),
        .key_o (keyout)
    );

    always_comb begin
        state_d   = state_q;
        key_ready = 1'b0;
        busy      = 1'b0;
        load      = 1'b0;
        step      = 1'b0;
        unique case (state_q)
            ST_IDLE, ST_READY: begin
                key_ready = ~zero_req;
                if (kif.key_valid && key_ready) begin
                    load    = 1'b1;
                    state_d = ST_EXPAND;
                end
            end
            ST_EXPAND: begin
                busy = 1'b1;
                step = 1'b1;
                if (rc_q == LAST_RC) state_d = ST_READY;
            end
            default: state_d = ST_IDLE;
        endcase
        if (zero_req) begin
            state_d = ST_IDLE;
            step    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            rc_q         <= '0;
            keys_valid_q <= 1'b0;
            rk_out_q     <= '0;
        end else begin
            state_q      <= state_d;
            keys_valid_q <= (state_d == ST_READY);
            if (load || zero_req)               rc_q <= '0;
            else if (step && rc_q != LAST_RC)   rc_q <= rc_q + 3'd1;
            // the buffer is only ever visible once the whole schedule is complete
            if (!zero_req && keys_valid_q && kif.rk_addr <= AW'(NUM_RK - 1))
                rk_out_q <= rk_q[kif.rk_addr];
            else
                rk_out_q <= '0;
        end
    end

    assign idx_hi = {rc_q, 1'b0} + AW'(2);
    assign idx_lo = idx_hi + AW'(1);

    always_comb begin
        work_d = work_q;
        rk_d   = rk_q;
        if (load) begin
            work_d = kif.key_in;
            rk_d[0] = kif.key_in[KEY_W-1 -: RK_W];
            rk_d[1] = kif.key_in[RK_W-1:0];
        end else if (step) begin
            work_d       = keyout;
            rk_d[idx_hi] = keyout[KEY_W-1 -: RK_W];
            // last step yields only rk[14]; its lower half is beyond the schedule
            if (rc_q != LAST_RC) rk_d[idx_lo] = keyout[RK_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
`ifdef KEYSCHED_ZEROIZE_EN
        if (rst || zeroize) begin
            work_q <= '0;
            rk_q   <= '{default: '0};
        end else
`endif
        begin
            work_q <= work_d;
            rk_q   <= rk_d;
        end
    end

    assign kif.key_ready  = key_ready;
    assign kif.busy       = busy;
    assign kif.keys_valid = keys_valid_q;
    assign kif.rk_out     = rk_out_q;
endmodule

// File: tb/tb_aes256_key_schedule_ctrl.sv
// Self-checking bench: FIPS-197 vectors, handshake corner cases and random keys vs a word-level model.
module tb_aes256_key_schedule_ctrl;
    typedef logic [14:0][127:0] rks_t;
    typedef struct {
        logic [255:0] key;
        logic [3:0]   addr;
        logic [127:0] exp;
    } vec_t;

    localparam logic [255:0] FIPS_KEY =
        256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

    logic clk = 1'b0;
    logic rst;
`ifdef KEYSCHED_ZEROIZE_EN
    logic zeroize;
`endif
    int   total = 0;
    int   bad   = 0;
    logic [7:0] sb [256];

    aes256_key_schedule_ctrl_if kif ();

    aes256_key_schedule_ctrl dut (
        .clk     (clk),
        .rst     (rst),
`ifdef KEYSCHED_ZEROIZE_EN
        .zeroize (zeroize),
`endif
        .kif     (kif.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00; x = a; y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            y = y >> 1;
        end
        return p;
    endfunction

    // S-box from the field inverse (a^254) followed by the affine map
    function automatic logic [7:0] sbox_calc(input logic [7:0] a);
        logic [7:0] b;
        b = 8'h01;
        for (int i = 0; i < 254; i++) b = gmul(b, a);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] subw(input logic [31:0] t);
        return {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
    endfunction

    function automatic rks_t expand_model(input logic [255:0] k);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  rc;
        rks_t        r;
        rc = 8'h01;
        for (int i = 0; i < 8; i++) w[i] = k[255-32*i -: 32];
        for (int i = 8; i < 60; i++) begin
            t = w[i-1];
            if (i % 8 == 0) begin
                t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end else if (i % 8 == 4) begin
                t = subw(t);
            end
            w[i] = w[i-8] ^ t;
        end
        for (int j = 0; j < 15; j++) r[j] = {w[4*j], w[4*j+1], w[4*j+2], w[4*j+3]};
        return r;
    endfunction

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic rd(input logic [3:0] a, output logic [127:0] d);
        kif.rk_addr = a;
        tick();
        d = kif.rk_out;
    endtask

    // latency counted with the handshake cycle as cycle 1: 1 capture + 7 steps = 8
    task automatic load_key(input logic [255:0] k);
        int n, lat, nb;
        kif.key_in    = k;
        kif.key_valid = 1'b1;
        n = 0;
        while (!kif.key_ready && n < 20) begin tick(); n++; end
        chk("ready before load", kif.key_ready, 1);
        tick();
        kif.key_valid = 1'b0;
        lat = 1; nb = 0;
        while (!kif.keys_valid && lat < 40) begin
            if (kif.busy) nb++;
            tick();
            lat++;
        end
        chk("keys_valid latency", lat, 8);
        chk("busy cycles", nb, 7);
    endtask

    task automatic sweep(input string nm, input logic [255:0] k);
        rks_t         m;
        logic [127:0] d;
        m = expand_model(k);
        for (int a = 0; a < 16; a++) begin
            rd(4'(a), d);
            chk($sformatf("%s rk[%0d]", nm, a), d, (a < 15) ? m[a] : 128'h0);
        end
    endtask

    initial begin
        vec_t         vt [6];
        logic [255:0] cur, ka, kb, kx;
        logic [127:0] d;
        rks_t         ma, mb;
        int           lat, rdy_hi, out_nz;

        vt[0] = '{FIPS_KEY, 4'd0,  128'h000102030405060708090a0b0c0d0e0f};
        vt[1] = '{FIPS_KEY, 4'd1,  128'h101112131415161718191a1b1c1d1e1f};
        vt[2] = '{FIPS_KEY, 4'd2,  128'ha573c29fa176c498a97fce93a572c09c};
        vt[3] = '{FIPS_KEY, 4'd3,  128'h1651a8cd0244beda1a5da4c10640bade};
        vt[4] = '{FIPS_KEY, 4'd14, 128'h24fc79ccbf0979e9371ac23c6d68de36};
        vt[5] = '{FIPS_KEY, 4'd15, 128'h0};

        for (int i = 0; i < 256; i++) sb[i] = sbox_calc(8'(i));

        rst = 1'b1;
        kif.key_in = '0; kif.key_valid = 1'b0; kif.rk_addr = '0;
`ifdef KEYSCHED_ZEROIZE_EN
        zeroize = 1'b0;
`endif
        @(negedge clk);
        tick(); tick();
        rst = 1'b0;
        chk("reset key_ready", kif.key_ready, 1);
        chk("reset busy", kif.busy, 0);
        chk("reset keys_valid", kif.keys_valid, 0);
        chk("reset rk_out", kif.rk_out, 0);
        rd(4'd0, d);
        chk("read before keys", d, 0);

        // FIPS-197 C.3 vectors
        cur = '1;
        for (int i = 0; i < 6; i++) begin
            if (vt[i].key !== cur) begin
                load_key(vt[i].key);
                cur = vt[i].key;
            end
            rd(vt[i].addr, d);
            chk($sformatf("table[%0d]", i), d, vt[i].exp);
        end

        // second key held during expansion is ignored until READY
        ka = {8{$urandom()}} ^ 256'h1234;
        kb = ~ka;
        ma = expand_model(ka);
        mb = expand_model(kb);
        kif.key_in = ka; kif.key_valid = 1'b1; kif.rk_addr = 4'd2;
        tick();
        kif.key_in = kb;
        rdy_hi = 0; out_nz = 0;
        for (int i = 0; i < 7; i++) begin
            if (kif.key_ready) rdy_hi++;
            if (i > 0 && kif.rk_out != 0) out_nz++;
            tick();
        end
        chk("ready low in expand", rdy_hi, 0);
        chk("rk_out zero in expand", out_nz, 0);
        chk("A keys_valid", kif.keys_valid, 1);
        chk("A key_ready", kif.key_ready, 1);
        tick();
        kif.key_valid = 1'b0;
        chk("A rk[2] at B accept", kif.rk_out, ma[2]);
        chk("B drops keys_valid", kif.keys_valid, 0);
        lat = 1;
        while (!kif.keys_valid && lat < 40) begin tick(); lat++; end
        chk("B latency", lat, 8);
        rd(4'd2, d);  chk("B rk[2]", d, mb[2]);
        rd(4'd14, d); chk("B rk[14]", d, mb[14]);

        // reset in the middle of expansion
        kx = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        kif.key_in = kx; kif.key_valid = 1'b1; kif.rk_addr = 4'd14;
        tick();
        kif.key_valid = 1'b0;
        tick(); tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst keys_valid", kif.keys_valid, 0);
        chk("rst key_ready", kif.key_ready, 1);
        chk("rst busy", kif.busy, 0);
        chk("rst rk_out", kif.rk_out, 0);
        rd(4'd14, d);
        chk("rst read rk[14]", d, 0);
        load_key(FIPS_KEY);
        sweep("fips", FIPS_KEY);

        // all-ones key
        load_key({256{1'b1}});
        sweep("ones", {256{1'b1}});

        // random keys against the model
        for (int n = 0; n < 6; n++) begin
            for (int j = 0; j < 8; j++) kx[32*j +: 32] = $urandom();
            load_key(kx);
            sweep($sformatf("rand%0d", n), kx);
        end

`ifdef KEYSCHED_ZEROIZE_EN
        zeroize = 1'b1;
        kif.key_valid = 1'b1;
        kif.key_in = FIPS_KEY;
        #1;
        chk("zeroize key_ready", kif.key_ready, 0);
        tick();
        zeroize = 1'b0;
        kif.key_valid = 1'b0;
        chk("zeroize keys_valid", kif.keys_valid, 0);
        chk("zeroize rk_out", kif.rk_out, 0);
        tick(); tick();
        chk("zeroize no expand", kif.busy, 0);
        chk("zeroize keys_valid held", kif.keys_valid, 0);
        rd(4'd14, d);
        chk("zeroize rk[14]", d, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
